piano_key_encoder: RTL

Upstream stage of the piano 7-segment display path. Synchronises and debounces eight note keys plus flat and octave buttons, then encodes them into the sel / flat / octave signals consumed by the tone/flat display and tone-generator blocks. It owns the held-note state machine and the octave toggle, so downstream blocks see clean, glitch-free levels.

---
 rtl/piano_pkg.sv | 31 +++
 rtl/key_debounce.sv | 54 +++++
 rtl/piano_key_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piano_pkg
// Description : Shared constants for the piano key encoder. Holds the note
//               codes driven on sel, the note FSM state encoding and the
//               number of note keys.
// Revision    : 1.0 - initial release
// ============================================================================
package piano_pkg;

    localparam int KEY_COUNT = 8;

    // Note codes on sel; 0 means silent, 9..15 are never produced.
    localparam logic [3:0] NOTE_NONE  = 4'd0;
    localparam logic [3:0] NOTE_DO    = 4'd1;
    localparam logic [3:0] NOTE_RE    = 4'd2;
    localparam logic [3:0] NOTE_MI    = 4'd3;
    localparam logic [3:0] NOTE_FA    = 4'd4;
    localparam logic [3:0] NOTE_SOL   = 4'd5;
    localparam logic [3:0] NOTE_LA    = 4'd6;
    localparam logic [3:0] NOTE_SI    = 4'd7;
    localparam logic [3:0] NOTE_DO_HI = 4'd8;

    // Note FSM encoding. ST_RELEASE is only reachable with KEY_SUSTAIN_EN.
    localparam int         STATE_W    = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-FF synchroniser followed by a stability-counter debouncer
//               for one raw button input.
// Ports       : clk  - system clock
//               rst  - synchronous reset, active-high
//               din  - raw asynchronous input
//               dout - debounced level (flips after DEB_CYCLES stable cycles)
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int                 c_CNT_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter only runs while the synced input disagrees with the
    // accepted level; any agreement (a bounce back) restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout = r_level;

endmodule
`default_nettype wire

// File: rtl/piano_key_encoder.sv
`default_nettype none
// ============================================================================
// Module      : piano_key_encoder
// Description : Debounces eight note keys plus flat/octave buttons and
//               encodes them into sel/flat/octave/note_on for the display
//               and tone-generator blocks.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               key[7:0]     - raw note keys (key[0]=Do .. key[7]=high Do)
//               flat_btn     - raw flat button
//               octave_btn   - raw octave button
//               sel[3:0]     - note code, 0 = silent, 1..8 = key index+1
//               flat         - debounced flat, forced 0 while silent
//               octave       - toggles on each accepted octave press
//               note_on      - one-cycle pulse when sel takes a new note
// Options     : KEY_SUSTAIN_EN - hold the note SUSTAIN_CYCLES after release
// Revision    : 1.0 - initial release
// ============================================================================
module piano_key_encoder
    import piano_pkg::*;
#(
    parameter int DEB_CYCLES     = 1000000,
    parameter int SUSTAIN_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] key,
    input  logic                 flat_btn,
    input  logic                 octave_btn,
    output logic [3:0]           sel,
    output logic                 flat,
    output logic                 octave,
    output logic                 note_on
);

    logic [KEY_COUNT-1:0] w_key_deb;
    logic                 w_flat_deb;
    logic                 w_oct_deb;
    logic [3:0]           w_pri;

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [3:0]           r_sel;
    logic [3:0]           w_sel_nxt;
    logic                 r_note_on;
    logic                 w_note_on_nxt;
    logic                 r_flat;
    logic                 r_octave;
    logic                 r_oct_prev;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < KEY_COUNT; gi++) begin : g_key_deb
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (key[gi]),
            .dout (w_key_deb[gi])
        );
    end

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_flat_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (flat_btn),
        .dout (w_flat_deb)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_oct_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (octave_btn),
        .dout (w_oct_deb)
    );

    // Lowest index wins: scan downward so the last hit is the lowest key.
    always_comb begin
        w_pri = NOTE_NONE;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (w_key_deb[i]) begin
                w_pri = NOTE_DO + 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Note FSM
    // ------------------------------------------------------------------
`ifdef KEY_SUSTAIN_EN
    localparam int               c_SUS_W    = $clog2(SUSTAIN_CYCLES) + 1;
    localparam logic [c_SUS_W-1:0] c_SUS_LAST = c_SUS_W'(SUSTAIN_CYCLES - 1);

    logic [c_SUS_W-1:0] r_sus_cnt;
    logic [c_SUS_W-1:0] w_sus_cnt_nxt;
`else
    logic w_unused_sus;
    assign w_unused_sus = (SUSTAIN_CYCLES > 0);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_note_on_nxt = 1'b0;
`ifdef KEY_SUSTAIN_EN
        w_sus_cnt_nxt = r_sus_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pri != NOTE_NONE) begin
                    w_state_nxt   = ST_PLAY;
                    w_sel_nxt     = w_pri;
                    w_note_on_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_pri == NOTE_NONE) begin
`ifdef KEY_SUSTAIN_EN
                    w_state_nxt   = ST_RELEASE;
                    w_sus_cnt_nxt = '0;
`else
                    w_state_nxt   = ST_IDLE;
                    w_sel_nxt     = NOTE_NONE;
`endif
                end else if (w_pri != r_sel) begin
                    w_sel_nxt     = w_pri;
                    w_note_on_nxt = 1'b1;
                end
            end
`ifdef KEY_SUSTAIN_EN
            ST_RELEASE: begin
                if (w_pri != NOTE_NONE) begin
                    // Re-pressing the sustained note resumes silently.
                    w_state_nxt   = ST_PLAY;
                    w_sel_nxt     = w_pri;
                    w_note_on_nxt = (w_pri != r_sel);
                end else if (r_sus_cnt == c_SUS_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = NOTE_NONE;
                end else begin
                    w_sus_cnt_nxt = r_sus_cnt + 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = NOTE_NONE;
            end
        endcase
    end

`ifdef KEY_SUSTAIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sus_cnt <= '0;
        end else begin
            r_sus_cnt <= w_sus_cnt_nxt;
        end
    end
`endif

    // flat is gated by the next sel so both outputs change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= NOTE_NONE;
            r_note_on  <= 1'b0;
            r_flat     <= 1'b0;
            r_octave   <= 1'b0;
            r_oct_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_note_on  <= w_note_on_nxt;
            r_flat     <= w_flat_deb & (w_sel_nxt != NOTE_NONE);
            r_oct_prev <= w_oct_deb;
            if (w_oct_deb & ~r_oct_prev) begin
                r_octave <= ~r_octave;
            end
        end
    end

    assign sel     = r_sel;
    assign flat    = r_flat;
    assign octave  = r_octave;
    assign note_on = r_note_on;

endmodule
`default_nettype wire
